// File: rtl/local_hist_bpu_pkg.sv
// -----------------------------------------------------------------------------
// bpu_pkg
//   Shared types and helpers for the local-history branch predictor.
//   - bpu_state_e : table-clear FSM states
//   - wnt()       : weakly-not-taken counter value for a given counter width
//   - ctr_next()  : saturating counter step, width-agnostic (up to 32 bits)
//   The entry record is declared inside local_hist_bpu, because its field
//   widths depend on that module's parameters.
// -----------------------------------------------------------------------------
package bpu_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bpu_state_e;

  // Weakly-not-taken: largest value whose MSB is still 0.
  function automatic int unsigned wnt(input int unsigned ctr_w);
    return (32'd1 << (ctr_w - 1)) - 32'd1;
  endfunction

  // One saturating step towards taken/not-taken; exact at 0 and ctr_max.
  function automatic logic [31:0] ctr_next(input logic [31:0] ctr,
                                           input logic        taken,
                                           input logic [31:0] ctr_max);
    if (taken) begin
      return (ctr >= ctr_max) ? ctr_max : ctr + 32'd1;
    end
    return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
  endfunction

endpackage

// File: rtl/local_hist_bpu_if.sv
// -----------------------------------------------------------------------------
// local_hist_bpu_if
//   Fetch-side lookup, EXE-side update and status/performance signals of the
//   local-history predictor.
//   master : pipeline side (drives lk_*/upd_*, observes pred_*, ready, cnt_*)
//   slave  : predictor side
// -----------------------------------------------------------------------------
interface local_hist_bpu_if #(
  parameter int HIST_W = 2,
  parameter int CTR_W  = 2
);
  localparam int META_W = HIST_W + CTR_W;

  logic              ready;
  logic              lk_valid;
  logic [31:0]       lk_pc;
  logic              lk_stall;
  logic              pred_valid;
  logic              pred_taken;
  logic [31:0]       pred_target;
  logic [META_W-1:0] pred_meta;
  logic              upd_valid;
  logic [31:0]       upd_pc;
  logic              upd_taken;
  logic [31:0]       upd_target;
  logic [META_W-1:0] upd_meta;
  logic              upd_mispredict;
  logic [31:0]       cnt_branch;
  logic [31:0]       cnt_mispred;

  modport master (
    input  ready, pred_valid, pred_taken, pred_target, pred_meta,
           cnt_branch, cnt_mispred,
    output lk_valid, lk_pc, lk_stall,
           upd_valid, upd_pc, upd_taken, upd_target, upd_meta, upd_mispredict
  );

  modport slave (
    output ready, pred_valid, pred_taken, pred_target, pred_meta,
           cnt_branch, cnt_mispred,
    input  lk_valid, lk_pc, lk_stall,
           upd_valid, upd_pc, upd_taken, upd_target, upd_meta, upd_mispredict
  );
endinterface

// File: rtl/local_hist_bpu_sat_ctr.sv
// -----------------------------------------------------------------------------
// bpu_sat_ctr
//   Combinational saturating counter update.
//   ctr_in  : current counter value (from the lookup snapshot)
//   taken   : resolved direction
//   ctr_out : incremented (taken) or decremented value, clamped to
//             [0, 2^CTR_W-1]
// -----------------------------------------------------------------------------
module bpu_sat_ctr
  import bpu_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr_in,
  input  logic             taken,
  output logic [CTR_W-1:0] ctr_out
);
  localparam logic [31:0] CTR_MAX = 32'((64'd1 << CTR_W) - 64'd1);

  always_comb begin
    ctr_out = CTR_W'(ctr_next(32'(ctr_in), taken, CTR_MAX));
  end
endmodule

// File: rtl/local_hist_bpu.sv
// -----------------------------------------------------------------------------
// local_hist_bpu
//   Per-PC local-history direction predictor with an integrated BTB.
//   Each entry: valid, tag, target, local history, 2^HIST_W counters.
//   Ports:
//     clk   : clock
//     rst_n : synchronous active-low reset
//     bus   : local_hist_bpu_if.slave
//             lk_*   lookup request, registered result on pred_* next cycle
//             upd_*  resolved branch from EXE, with the pred_meta snapshot
//             ready  table cleared, lookups valid
//             cnt_*  resolved-branch and mispredict counts (wrap at 2^32)
//   After reset the table is cleared one entry per cycle (2^IDX_W cycles).
//   A lookup that hits the index being updated in the same cycle sees the
//   post-update entry.
// -----------------------------------------------------------------------------
module local_hist_bpu
  import bpu_pkg::*;
#(
  parameter int IDX_W  = 9,
  parameter int HIST_W = 2,
  parameter int CTR_W  = 2,
  parameter int TAG_W  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  local_hist_bpu_if.slave bus
);

  if (HIST_W < 1 || CTR_W < 2) begin : g_bad_params
    $error("local_hist_bpu: HIST_W >= 1 and CTR_W >= 2 are required");
  end

  localparam int N_ENT  = 1 << IDX_W;
  localparam int N_CTR  = 1 << HIST_W;
  localparam int META_W = HIST_W + CTR_W;
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = IDX_W + TAG_W + 1;

  typedef logic [CTR_W-1:0] ctr_t;

  localparam ctr_t WNT_C = CTR_W'(wnt(CTR_W));

  typedef struct packed {
    logic                   valid;
    logic [TAG_W-1:0]       tag;
    logic [31:0]            target;
    logic [HIST_W-1:0]      history;
    ctr_t [N_CTR-1:0]       counters;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Storage and FSM state
  // ---------------------------------------------------------------------------
  entry_t           ent_q [N_ENT];
  bpu_state_e       state_q, state_d;
  logic [IDX_W-1:0] clr_ptr_q, clr_ptr_d;

  logic run;
  assign run = (state_q == RUN);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]  lk_idx, upd_idx;
  logic [TAG_W-1:0]  lk_tag, upd_tag;
  logic [HIST_W-1:0] upd_hist;
  ctr_t              upd_ctr, upd_ctr_nxt;
  logic              upd_fire;

  assign lk_idx   = bus.lk_pc[IDX_W+1:2];
  assign lk_tag   = bus.lk_pc[TAG_HI:TAG_LO];
  assign upd_idx  = bus.upd_pc[IDX_W+1:2];
  assign upd_tag  = bus.upd_pc[TAG_HI:TAG_LO];
  assign upd_hist = bus.upd_meta[META_W-1:CTR_W];
  assign upd_ctr  = bus.upd_meta[CTR_W-1:0];
  assign upd_fire = run && bus.upd_valid;

  // PC bits outside index/tag never take part in prediction.
  logic unused_upd_pc_bits;
  assign unused_upd_pc_bits = ^{bus.upd_pc[31:TAG_HI+1], bus.upd_pc[1:0]};

  bpu_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
    .ctr_in  (upd_ctr),
    .taken   (bus.upd_taken),
    .ctr_out (upd_ctr_nxt)
  );

  // ---------------------------------------------------------------------------
  // Entry images: cleared entry, post-update entry, bypassed lookup entry
  // ---------------------------------------------------------------------------
  entry_t clr_ent, upd_cur, upd_new, lk_ent;
  ctr_t   lk_ctr;
  logic   lk_hit, lk_taken;
  logic [31:0] lk_target;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    clr_ent = '0;
    for (int i = 0; i < N_CTR; i++) begin
      clr_ent.counters[i] = WNT_C;
    end
  end

  always_comb begin
    upd_cur         = ent_q[upd_idx];
    upd_new         = upd_cur;
    upd_new.valid   = 1'b1;
    upd_new.tag     = upd_tag;
    if (bus.upd_taken) begin
      upd_new.target = bus.upd_target;
    end
    // Shift in the outcome on the entry's live history; truncation drops the
    // oldest bit (also correct for HIST_W == 1).
    upd_new.history = HIST_W'({upd_cur.history, bus.upd_taken});
    // Counter comes from the snapshot, so a stale snapshot overwrites.
    upd_new.counters[upd_hist] = upd_ctr_nxt;
  end

  always_comb begin
    lk_ent    = (upd_fire && (upd_idx == lk_idx)) ? upd_new : ent_q[lk_idx];
    lk_hit    = lk_ent.valid && (lk_ent.tag == lk_tag);
    lk_ctr    = lk_ent.counters[lk_ent.history];
    lk_taken  = lk_hit && lk_ctr[CTR_W-1];
    lk_target = lk_taken ? lk_ent.target : bus.lk_pc + 32'd4;
  end

  // ---------------------------------------------------------------------------
  // Table-clear FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      INIT: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == IDX_W'(N_ENT - 1)) begin
          state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= INIT;
      clr_ptr_q <= '0;
      bus.ready <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      bus.ready <= (state_d == RUN);
    end
  end

  // NOTE: the table has no reset branch; the INIT sweep clears it, which keeps
  // the array a plain write-port memory instead of 2^IDX_W resettable flops.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!run) begin
        ent_q[clr_ptr_q] <= clr_ent;
      end else if (bus.upd_valid) begin
        ent_q[upd_idx] <= upd_new;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prediction registers and performance counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.pred_valid  <= 1'b0;
      bus.pred_taken  <= 1'b0;
      bus.pred_target <= '0;
      bus.pred_meta   <= '0;
      bus.cnt_branch  <= '0;
      bus.cnt_mispred <= '0;
    end else if (run) begin
      if (!bus.lk_stall) begin
        bus.pred_valid  <= bus.lk_valid;
        bus.pred_taken  <= lk_taken;
        bus.pred_target <= lk_target;
        bus.pred_meta   <= {lk_ent.history, lk_ctr};
      end
      if (bus.upd_valid) begin
        bus.cnt_branch <= bus.cnt_branch + 32'd1;
        if (bus.upd_mispredict) begin
          bus.cnt_mispred <= bus.cnt_mispred + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_local_hist_bpu.sv
// -----------------------------------------------------------------------------
// tb_local_hist_bpu
//   Directed bench for local_hist_bpu (default parameters). Lookups push their
//   hand-computed result into a queue; a monitor on the falling edge pops and
//   compares whenever a fresh prediction is presented, and compares held
//   outputs against the last result while the lookup stage is stalled.
// -----------------------------------------------------------------------------
module tb_local_hist_bpu;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  local_hist_bpu_if #(.HIST_W(2), .CTR_W(2)) bus ();

  local_hist_bpu #(
    .IDX_W  (9),
    .HIST_W (2),
    .CTR_W  (2),
    .TAG_W  (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [3:0]  meta;
  } pred_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  pred_t exp_q[$];
  pred_t last_exp = '0;
  logic  cap_stall = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cmp_pred(input string name, input pred_t e);
    check({name, "_taken"},  32'(bus.pred_taken), 32'(e.taken));
    check({name, "_target"}, bus.pred_target,     e.target);
    check({name, "_meta"},   32'(bus.pred_meta),  32'(e.meta));
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(posedge clk) cap_stall = bus.lk_stall;

  always @(negedge clk) begin
    if (bus.pred_valid) begin
      if (!cap_stall) begin
        if (exp_q.size() == 0) begin
          check("pred_valid_unexpected", 32'(bus.pred_valid), 32'd0);
        end else begin
          last_exp = exp_q.pop_front();
          cmp_pred("pred", last_exp);
        end
      end else begin
        cmp_pred("stall_hold", last_exp);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers (all called at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic idle();
    bus.lk_valid       = 1'b0;
    bus.lk_stall       = 1'b0;
    bus.upd_valid      = 1'b0;
    bus.upd_mispredict = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  task automatic set_lk(input logic [31:0] pc, input logic tk,
                        input logic [31:0] tgt, input logic [3:0] meta);
    pred_t e;
    e.taken  = tk;
    e.target = tgt;
    e.meta   = meta;
    bus.lk_valid = 1'b1;
    bus.lk_pc    = pc;
    exp_q.push_back(e);
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic [3:0] meta,
                         input logic mis);
    bus.upd_valid      = 1'b1;
    bus.upd_pc         = pc;
    bus.upd_taken      = tk;
    bus.upd_target     = tgt;
    bus.upd_meta       = meta;
    bus.upd_mispredict = mis;
  endtask

  // Called right after rst_n is released at a falling edge.
  task automatic init_wait(input string name);
    int cyc = 0;
    while (!bus.ready && cyc < 600) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    idle();
    check({name, "_init_cycles"}, 32'(cyc), 32'd512);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ready"},       32'(bus.ready),       32'd0);
    check({name, "_pred_valid"},  32'(bus.pred_valid),  32'd0);
    check({name, "_pred_taken"},  32'(bus.pred_taken),  32'd0);
    check({name, "_pred_target"}, bus.pred_target,      32'd0);
    check({name, "_pred_meta"},   32'(bus.pred_meta),   32'd0);
    check({name, "_cnt_branch"},  bus.cnt_branch,       32'd0);
    check({name, "_cnt_mispred"}, bus.cnt_mispred,      32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    idle();
    bus.lk_pc = '0; bus.upd_pc = '0; bus.upd_taken = 1'b0;
    bus.upd_target = '0; bus.upd_meta = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // First INIT, with lookups and updates that must be ignored
    set_upd(32'h0000_1000, 1'b1, 32'h0000_9000, 4'b0001, 1'b1);
    bus.lk_valid = 1'b1;
    bus.lk_pc    = 32'h0000_1000;
    rst_n = 1'b1;
    init_wait("init0");
    check("init0_cnt_branch",  bus.cnt_branch,  32'd0);
    check("init0_cnt_mispred", bus.cnt_mispred, 32'd0);
    check("init0_pred_valid",  32'(bus.pred_valid), 32'd0);

    // Cold lookup
    set_lk(32'h0000_1000, 1'b0, 32'h0000_1004, 4'b0001); step();

    // Train 0x1000 taken three times with the latest snapshot
    set_upd(32'h0000_1000, 1'b1, 32'h0000_2000, 4'b0001, 1'b0); step();
    set_lk (32'h0000_1000, 1'b0, 32'h0000_1004, 4'b0101);       step();
    set_upd(32'h0000_1000, 1'b1, 32'h0000_2000, 4'b0101, 1'b0); step();
    set_lk (32'h0000_1000, 1'b0, 32'h0000_1004, 4'b1101);       step();
    set_upd(32'h0000_1000, 1'b1, 32'h0000_2000, 4'b1101, 1'b0); step();
    set_lk (32'h0000_1000, 1'b1, 32'h0000_2000, 4'b1110);       step();

    // Tag alias: same index, different tag
    set_lk(32'h0000_1800, 1'b0, 32'h0000_1804, 4'b1110); step();

    // Saturation high then low on index 16
    set_upd(32'h0000_0040, 1'b1, 32'h0000_0400, 4'b1111, 1'b0); step();
    set_upd(32'h0000_0040, 1'b1, 32'h0000_0400, 4'b1111, 1'b0); step();
    set_lk (32'h0000_0040, 1'b1, 32'h0000_0400, 4'b1111);       step();
    set_upd(32'h0000_0040, 1'b0, 32'h0000_0000, 4'b0000, 1'b0); step();
    set_upd(32'h0000_0040, 1'b0, 32'h0000_0000, 4'b0000, 1'b0); step();
    set_lk (32'h0000_0040, 1'b0, 32'h0000_0044, 4'b0000);       step();

    // Same-cycle update and lookup on index 32 (write-first)
    set_upd(32'h0000_0080, 1'b1, 32'h0000_3000, 4'b0001, 1'b0);
    set_lk (32'h0000_0080, 1'b0, 32'h0000_0084, 4'b0101); step();
    set_upd(32'h0000_0080, 1'b1, 32'h0000_3000, 4'b0101, 1'b0);
    set_lk (32'h0000_0080, 1'b0, 32'h0000_0084, 4'b1101); step();
    set_upd(32'h0000_0080, 1'b1, 32'h0000_3000, 4'b1101, 1'b0);
    set_lk (32'h0000_0080, 1'b1, 32'h0000_3000, 4'b1110); step();

    // Stall: outputs must hold for three cycles despite a new lookup
    for (int i = 0; i < 3; i++) begin
      bus.lk_stall = 1'b1;
      bus.lk_valid = 1'b1;
      bus.lk_pc    = 32'h0000_1000;
      @(negedge clk);
    end
    idle();
    @(negedge clk);

    check("run_cnt_branch",  bus.cnt_branch,  32'd10);
    check("run_cnt_mispred", bus.cnt_mispred, 32'd0);

    // Mid-RUN reset, then 10 updates with 4 mispredicts
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_run");
    rst_n = 1'b1;
    init_wait("init1");
    for (int i = 0; i < 10; i++) begin
      set_upd(32'h0000_1000, 1'b1, 32'h0000_5000, 4'b0001,
              (i == 1 || i == 4 || i == 6 || i == 9));
      step();
    end
    check("perf_cnt_branch",  bus.cnt_branch,  32'd10);
    check("perf_cnt_mispred", bus.cnt_mispred, 32'd4);

    // Reset, then reset again at INIT cycle 200: full INIT must restart
    rst_n = 1'b0;
    @(negedge clk);
    check("rst2_cnt_branch",  bus.cnt_branch,  32'd0);
    check("rst2_cnt_mispred", bus.cnt_mispred, 32'd0);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("mid_init_ready", 32'(bus.ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_mid_init");
    rst_n = 1'b1;
    init_wait("init2");

    // Table must be cleared again: entry 0 trained above now misses
    set_lk(32'h0000_1000, 1'b0, 32'h0000_1004, 4'b0001); step();
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/local_hist_bpu.md
Name: local_hist_bpu

Overview:
- Parametrised per-PC local-history branch predictor with integrated BTB (branch target buffer), for the IF stage of the pipelined core.
- Each entry holds a local history shift register, 2^HIST_W saturating counters selected by that history, a valid bit, a tag and a target.
- Lookup is registered with one-cycle latency. Update comes from EXE with a snapshot of the lookup metadata.
- Adds three things: table-clear FSM after reset, same-cycle update→lookup bypass (no hazard suppression), and performance counters.

Parameters:
- IDX_W, 9, log2 of entry count; index = pc[IDX_W+1:2]
- HIST_W, 2, local history bits per entry; 2^HIST_W counters per entry
- CTR_W, 2, saturating counter width; predict taken when counter MSB = 1
- TAG_W, 8, BTB tag bits = pc[IDX_W+TAG_W+1:IDX_W+2]

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- ready  out  1  table initialised; lookups valid
- lk_valid  in  1  lookup request
- lk_pc  in  32  fetch PC
- lk_stall  in  1  hold lookup output registers
- pred_valid  out  1  prediction outputs meaningful
- pred_taken  out  1  predicted taken
- pred_target  out  32  predicted next PC
- pred_meta  out  HIST_W+CTR_W  {history, selected counter} snapshot
- upd_valid  in  1  resolved conditional branch
- upd_pc  in  32  branch PC
- upd_taken  in  1  actual direction
- upd_target  in  32  actual taken target
- upd_meta  in  HIST_W+CTR_W  pred_meta carried down the pipe
- upd_mispredict  in  1  direction or target mispredicted
- cnt_branch  out  32  resolved branch count
- cnt_mispred  out  32  mispredict count

Behaviour:
- States: INIT, RUN.
- On rst_n=0 at posedge:
  - state←INIT, clear pointer←0.
  - All outputs←0: ready, pred_valid, pred_taken, pred_target, pred_meta, cnt_branch, cnt_mispred.
  - Applies mid-operation too; the clear restarts from entry 0.
- INIT clears one entry per cycle: valid←0, history←0, all counters←WNT = 2^(CTR_W-1)-1, tag and target←0.
- After entry 2^IDX_W-1: state←RUN and ready←1. Total INIT duration is exactly 2^IDX_W cycles.
- In INIT, lk_valid and upd_valid are ignored, pred_valid stays 0, and the counters do not increment.
- Lookup (RUN), request at cycle t with lk_stall=0. Outputs registered at t+1:
  - hit = valid & tag match; ctr = counters[history].
  - pred_taken = hit & ctr[CTR_W-1].
  - pred_target = pred_taken ? stored target : lk_pc+4.
  - pred_meta = {history, ctr}; pred_valid = lk_valid.
- lk_stall=1: all pred_* registers hold their values regardless of lk_valid.
- Update (RUN, upd_valid=1), at posedge, using uh = upd_meta history and uc = upd_meta counter:
  - counters[uh] ← upd_taken ? min(uc+1, 2^CTR_W-1) : max(uc-1, 0); the other counters are untouched.
  - history ← {history[HIST_W-2:0], upd_taken}, computed from the entry's current history, not uh.
  - valid←1, tag←upd tag.
  - target←upd_target only when upd_taken=1.
  - The counter is computed from the snapshot, not re-read: a stale snapshot overwrites, by design.
- Bypass: if lookup and update hit the same index in the same cycle, the lookup result reflects the post-update entry (write-first). No prediction suppression.
- Performance counters:
  - cnt_branch += 1 per accepted update.
  - cnt_mispred += 1 when upd_valid & upd_mispredict.
  - Both wrap modulo 2^32.
- Arithmetic: lk_pc+4 is a 32-bit wrap. Counter saturation is exact at 0 and 2^CTR_W-1.
- HIST_W ≥ 1 and CTR_W ≥ 2 are required; elaboration fails otherwise.

Decomposition:
- Shared package bpu_pkg:
  - state enum {INIT, RUN}
  - entry struct {valid, tag, target, history, counters}
  - function ctr_next(ctr, taken)
  - WNT constant expression
- One sub-module, bpu_sat_ctr: combinational saturating counter update. Everything else is inline.

Test Plan:
- Reset, then idle: ready=0 for 512 cycles, ready=1 at cycle 512. A lookup at 0x0000_1000 then gives pred_valid=1, pred_taken=0, pred_target=0x0000_1004.
- Three updates taken at PC 0x1000, target 0x2000, each carrying the latest pred_meta. A subsequent lookup gives pred_taken=1, pred_target=0x2000, and history=2'b11 in pred_meta.
- Tag alias: train 0x1000 taken, then look up 0x1000+0x800 (same index, different tag) → pred_taken=0, target 0x1804.
- Saturation: updates with upd_meta={2'b11,2'b11}, upd_taken=1 → counters[3] stays 3. With upd_meta={2'b00,2'b00}, upd_taken=0 → counters[0] stays 0.
- Bypass and stall:
  - Same-cycle update(taken) and lookup on the same index → next-cycle pred_meta shows the updated history and counter.
  - With lk_stall=1 for 3 cycles, the outputs stay constant.
- Counters and reset mid-INIT:
  - 10 updates with 4 mispredicts → cnt_branch=10, cnt_mispred=4.
  - Asserting rst_n=0 at INIT cycle 200 → counters zero and a full 512-cycle INIT restarts.
